pic_cascade_ctrl: RTL
=====================

# pic_cascade_ctrl

Parametrised cascade-bus controller for the PIC, the successor of the fixed 3-line cascade block. It tracks the INTA pulse sequence (8080 three-pulse or 8086 two-pulse mode), drives or decodes the CAS bus as master or slave, and tells the data-bus buffer when to drive the CALL opcode or the vector. It sits between control logic (ICW3/ICW4 fields), the priority resolver, and the data-bus buffer.

## Interface
- CAS_W, 3: cascade address width; number of IR levels is 2**CAS_W.
- GAP_TIMEOUT, 64: maximum clk cycles INTA may stay high between pulses of one sequence before the sequence is aborted.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- SNGL  in  1  ICW1 single mode; 1 = no cascade.
- SP_EN  in  1  1 = master, 0 = slave; ignored when SNGL=1.
- UPM  in  1  ICW4 µPM; 1 = 8086 mode (2 pulses), 0 = 8080 mode (3 pulses).
- ICW3  in  2**CAS_W  master: bit i = slave on IR i; slave: bits [CAS_W-1:0] = own ID.
- INTA  in  1  active-low acknowledge, synchronous to clk.
- irq_valid  in  1  priority resolver has a winning level.
- irq_level  in  CAS_W  winning IR level.
- CAS_in  in  CAS_W  sampled CAS pins.
- CAS_out  out  CAS_W  CAS value to drive.
- CAS_oe  out  1  CAS pin output enable.
- ack_level  out  CAS_W  level latched for this sequence.
- opcode_en  out  1  drive CALL opcode (0xCD) on data bus.
- vec_en  out  1  drive vector bytes on data bus.
- seq_done  out  1  one-cycle pulse, sequence completed.
- seq_abort  out  1  one-cycle pulse, sequence timed out.

## Operation
- Edge detect: inta_q = INTA registered. Leading edge = inta_q & ~INTA; trailing edge = ~inta_q & INTA.
- Pulses per sequence: NP = UPM ? 2 : 3. Pulse index idx counts 1..NP.
- FSM states: IDLE, PULSE, GAP.
  - IDLE -> PULSE on leading edge; idx=1; latch ack_level = irq_valid ? irq_level : all-ones (spurious).
  - PULSE -> GAP on trailing edge when idx<NP; timer cleared.
  - PULSE -> IDLE on trailing edge when idx==NP; seq_done pulses.
  - GAP -> PULSE on leading edge; idx increments.
  - GAP -> IDLE when timer reaches GAP_TIMEOUT; seq_abort pulses.
- Role: single = SNGL; master = ~SNGL & SP_EN; slave = ~SNGL & ~SP_EN. Role inputs are sampled only at IDLE->PULSE and held for the sequence.
- Master: cascaded = ICW3[ack_level]. If cascaded, CAS_oe=1 and CAS_out=ack_level from the leading edge of pulse 1 to the trailing edge of pulse NP. Otherwise CAS_oe=0, CAS_out=0.
- Slave: CAS_oe=0 always. At the trailing edge of pulse 1, sel = (CAS_in == ICW3[CAS_W-1:0]).
- opcode_en: 1 during pulse 1 in 8080 mode, for master or single only. Never asserted in 8086 mode or for a slave.
- vec_en: 1 during pulses 2..NP when any of these holds:
  - single mode;
  - master mode with ~cascaded;
  - slave mode with sel=1.
- Outside a sequence, CAS_out=0 and CAS_oe, opcode_en, vec_en, sel are all 0.

## Timing
- All outputs are registered. An output change is visible one cycle after the clk edge at which the causing INTA edge is detected (two cycles after INTA changes).
- On the trailing edge of the last pulse, seq_done is 1 and CAS_oe/vec_en are 0 in the same cycle.
- Leading edge while in PULSE cannot occur by construction. A trailing edge in IDLE or GAP is ignored.
- Reset, including mid-sequence, forces:
  - state IDLE, idx=0, timer=0, inta_q=1;
  - CAS_out=0, CAS_oe=0, ack_level=0;
  - opcode_en=0, vec_en=0, seq_done=0, seq_abort=0.
- ICW3/UPM changes mid-sequence have no effect until the next sequence.
- GAP timer width is clog2(GAP_TIMEOUT+1). Its terminal count is compared with ==.

## Structure
- Package pic_pkg holds:
  - FSM state enum;
  - CALL_OPCODE = 8'hCD;
  - NP_8080 = 3, NP_8086 = 2.
- Sub-module pic_inta_seq holds the edge detect, FSM, idx and gap timer. It outputs in_pulse, idx, seq_done and seq_abort. The top level holds role latching, CAS and enable logic.

## Test plan
- Master, 8080, ICW3=8'h04, irq_level=2, three INTA pulses -> CAS_oe=1 with CAS_out=3'd2 through pulse 3 trailing edge; opcode_en only in pulse 1; vec_en never; seq_done once.
- Master, 8086, ICW3=8'h00, irq_level=5, two pulses -> CAS_oe=0; vec_en during pulse 2 only; opcode_en never.
- Slave, ID=3, 8080:
  - CAS_in=3 at pulse-1 trailing edge -> vec_en in pulses 2 and 3;
  - repeat with CAS_in=4 -> vec_en never.
- Single, irq_valid=0, 8080 -> ack_level=7; opcode_en in pulse 1; vec_en in pulses 2 and 3; CAS_oe=0.
- One pulse then INTA held high GAP_TIMEOUT cycles -> seq_abort pulses, state IDLE, all enables 0; next pulse starts a fresh sequence with idx=1.
- rst asserted during pulse 2 of a master cascaded sequence -> next cycle every output is at its reset value; the following INTA is treated as pulse 1.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC cascade-bus controller.
package pic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2
   } inta_state_e;

   localparam logic [7:0] CALL_OPCODE = 8'hCD;
   localparam int         NP_8080     = 3;
   localparam int         NP_8086     = 2;

   // Number of INTA pulses that make up one acknowledge sequence.
   function automatic logic [1:0] np_of(input logic upm);
      return upm ? 2'(NP_8086) : 2'(NP_8080);
   endfunction

endpackage

// File: rtl/pic_cascade_ctrl_if.sv
// Bundle of control-logic, priority-resolver, CAS and data-bus-buffer signals
// seen by the cascade controller. The slave modport is the controller side.
interface pic_cascade_ctrl_if #(
   parameter int CAS_W = 3
);
   logic                  SNGL;
   logic                  SP_EN;
   logic                  UPM;
   logic [2**CAS_W-1:0]   ICW3;
   logic                  INTA;
   logic                  irq_valid;
   logic [CAS_W-1:0]      irq_level;
   logic [CAS_W-1:0]      CAS_in;
   logic [CAS_W-1:0]      CAS_out;
   logic                  CAS_oe;
   logic [CAS_W-1:0]      ack_level;
   logic                  opcode_en;
   logic                  vec_en;
   logic                  seq_done;
   logic                  seq_abort;

   modport master (
      output SNGL, SP_EN, UPM, ICW3, INTA, irq_valid, irq_level, CAS_in,
      input  CAS_out, CAS_oe, ack_level, opcode_en, vec_en, seq_done, seq_abort
   );

   modport slave (
      input  SNGL, SP_EN, UPM, ICW3, INTA, irq_valid, irq_level, CAS_in,
      output CAS_out, CAS_oe, ack_level, opcode_en, vec_en, seq_done, seq_abort
   );

endinterface

// File: rtl/pic_inta_seq.sv
// INTA pulse sequencer: edge detection, IDLE/PULSE/GAP state machine,
// pulse index and inter-pulse gap timer.
import pic_pkg::*;

module pic_inta_seq #(
   parameter int GAP_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inta_i,
   input  logic       upm_i,
   output logic       in_pulse_o,
   output logic [1:0] idx_o,
   output logic       seq_done_o,
   output logic       seq_abort_o
);

   localparam int TW = $clog2(GAP_TIMEOUT + 1);

   inta_state_e   state_q;
   logic          inta_q;
   logic          inPulse_q;
   logic          seqDone_q;
   logic          seqAbort_q;
   logic [1:0]    idx_q;
   logic [1:0]    np_q;
   logic [TW-1:0] timer_q;
   logic          leadEdge;
   logic          trailEdge;

   assign leadEdge  = inta_q & ~inta_i;
   assign trailEdge = ~inta_q & inta_i;

   // Sequence state machine; the pulse count is frozen at the first leading
   // edge so a UPM change mid-sequence only affects the next sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         inta_q     <= 1'b1;
         inPulse_q  <= 1'b0;
         seqDone_q  <= 1'b0;
         seqAbort_q <= 1'b0;
         idx_q      <= 2'd0;
         np_q       <= 2'd0;
         timer_q    <= '0;
      end else begin
         inta_q     <= inta_i;
         seqDone_q  <= 1'b0;
         seqAbort_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (leadEdge) begin
                  state_q   <= ST_PULSE;
                  inPulse_q <= 1'b1;
                  idx_q     <= 2'd1;
                  np_q      <= np_of(upm_i);
               end
            end
            ST_PULSE: begin
               if (trailEdge) begin
                  inPulse_q <= 1'b0;
                  if (idx_q == np_q) begin
                     state_q   <= ST_IDLE;
                     idx_q     <= 2'd0;
                     seqDone_q <= 1'b1;
                  end else begin
                     state_q <= ST_GAP;
                     timer_q <= '0;
                  end
               end
            end
            ST_GAP: begin
               if (leadEdge) begin
                  state_q   <= ST_PULSE;
                  inPulse_q <= 1'b1;
                  idx_q     <= idx_q + 2'd1;
               end else if (timer_q == TW'(GAP_TIMEOUT)) begin
                  state_q    <= ST_IDLE;
                  idx_q      <= 2'd0;
                  seqAbort_q <= 1'b1;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               inPulse_q <= 1'b0;
               idx_q     <= 2'd0;
            end
         endcase
      end
   end

   assign in_pulse_o  = inPulse_q;
   assign idx_o       = idx_q;
   assign seq_done_o  = seqDone_q;
   assign seq_abort_o = seqAbort_q;

endmodule

// File: rtl/pic_cascade_ctrl.sv
// PIC cascade-bus controller: latches role and level for each acknowledge
// sequence, drives or decodes the CAS bus and gates the data-bus buffer.
import pic_pkg::*;

module pic_cascade_ctrl #(
   parameter int CAS_W       = 3,
   parameter int GAP_TIMEOUT = 64
) (
   input logic              clk,
   input logic              rst,
   pic_cascade_ctrl_if.slave bus
);

   logic             inPulse;
   logic [1:0]       idx;
   logic             seqDone;
   logic             seqAbort;

   logic             seqActive_q;
   logic             sngl_q;
   logic             master_q;
   logic             upm_q;
   logic             casc_q;
   logic [CAS_W-1:0] level_q;
   logic [CAS_W-1:0] slaveId_q;
   logic             sel_q;
   logic [CAS_W-1:0] casOut_q;
   logic             casOe_q;
   logic             opcodeEn_q;
   logic             vecEn_q;
   logic             seqDone_q;
   logic             seqAbort_q;

   logic             startNow;
   logic             seqLive;
   logic             effSngl;
   logic             effMaster;
   logic             effSlave;
   logic             effUpm;
   logic             effCasc;
   logic [CAS_W-1:0] effLevel;
   logic [CAS_W-1:0] effId;
   logic             sel_d;
   logic [CAS_W-1:0] casOut_d;
   logic             casOe_d;
   logic             opcodeEn_d;
   logic             vecEn_d;

   pic_inta_seq #(
      .GAP_TIMEOUT (GAP_TIMEOUT)
   ) uSeq (
      .clk         (clk),
      .rst         (rst),
      .inta_i      (bus.INTA),
      .upm_i       (bus.UPM),
      .in_pulse_o  (inPulse),
      .idx_o       (idx),
      .seq_done_o  (seqDone),
      .seq_abort_o (seqAbort)
   );

   // On the first cycle of a sequence the live inputs are used directly so the
   // outputs for pulse 1 are not delayed by the role latches.
   always_comb begin
      startNow  = inPulse & ~seqActive_q;
      effSngl   = sngl_q;
      effMaster = master_q;
      effUpm    = upm_q;
      effLevel  = level_q;
      effCasc   = casc_q;
      effId     = slaveId_q;
      if (startNow) begin
         effSngl   = bus.SNGL;
         effMaster = ~bus.SNGL & bus.SP_EN;
         effUpm    = bus.UPM;
         effLevel  = bus.irq_valid ? bus.irq_level : '1;
         effCasc   = bus.ICW3[effLevel];
         effId     = bus.ICW3[CAS_W-1:0];
      end
      effSlave = ~effSngl & ~effMaster;
      seqLive  = (startNow | seqActive_q) & ~seqDone & ~seqAbort;

      sel_d = 1'b0;
      if (seqLive && effSlave) begin
         sel_d = (inPulse && idx == 2'd1) ? (bus.CAS_in == effId) : sel_q;
      end

      casOe_d    = seqLive & effMaster & effCasc;
      casOut_d   = casOe_d ? effLevel : '0;
      opcodeEn_d = seqLive & inPulse & (idx == 2'd1) & ~effUpm & ~effSlave;
      vecEn_d    = seqLive & inPulse & (idx >= 2'd2) &
                   (effSngl | (effMaster & ~effCasc) | (effSlave & sel_q));
   end

   // Role latches and registered outputs; everything returns to idle values
   // on reset, even mid-sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         seqActive_q <= 1'b0;
         sngl_q      <= 1'b0;
         master_q    <= 1'b0;
         upm_q       <= 1'b0;
         casc_q      <= 1'b0;
         level_q     <= '0;
         slaveId_q   <= '0;
         sel_q       <= 1'b0;
         casOut_q    <= '0;
         casOe_q     <= 1'b0;
         opcodeEn_q  <= 1'b0;
         vecEn_q     <= 1'b0;
         seqDone_q   <= 1'b0;
         seqAbort_q  <= 1'b0;
      end else begin
         seqActive_q <= seqLive;
         if (startNow) begin
            sngl_q    <= effSngl;
            master_q  <= effMaster;
            upm_q     <= effUpm;
            casc_q    <= effCasc;
            level_q   <= effLevel;
            slaveId_q <= effId;
         end
         sel_q      <= sel_d;
         casOut_q   <= casOut_d;
         casOe_q    <= casOe_d;
         opcodeEn_q <= opcodeEn_d;
         vecEn_q    <= vecEn_d;
         seqDone_q  <= seqDone;
         seqAbort_q <= seqAbort;
      end
   end

   assign bus.CAS_out   = casOut_q;
   assign bus.CAS_oe    = casOe_q;
   assign bus.ack_level = level_q;
   assign bus.opcode_en = opcodeEn_q;
   assign bus.vec_en    = vecEn_q;
   assign bus.seq_done  = seqDone_q;
   assign bus.seq_abort = seqAbort_q;

endmodule
